// File: rtl/double_trouble_arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package double_trouble_arb_pkg;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned POP_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index of the set bit in a one-hot vector (zero for an all-zero vector).
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NREQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = PTR_W'(unsigned'(i));
    end
    return idx;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [NREQ-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NREQ; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/double_trouble_arb_rr_pick4.sv
// Combinational rotating priority pick: first set req bit searching upward from start.
module rr_pick4
  import double_trouble_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] start,
  output logic [NREQ-1:0]  pick,
  output logic             valid
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    pick  = '0;
    valid = |req;
    idx   = '0;
    // Walk the order backwards so the earliest candidate overwrites later ones.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = start + PTR_W'(unsigned'(i));
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/double_trouble_arb.sv
// Round-robin arbiter with bounded hold time and a saturating contention counter.
module double_trouble_arb
  import double_trouble_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             clr,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             contention,
  output logic [CNT_W-1:0] contention_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state, state_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic [PTR_W-1:0]  owner_next;
  logic [NREQ-1:0]   others;
  logic              own_req;
  logic              others_any;
  logic [NREQ-1:0]   idle_pick, hand_pick;
  logic              idle_valid, hand_valid;
  logic              multi;

  assign owner_next = onehot_idx(gnt) + PTR_W'(1);
  assign others     = req & ~gnt;
  assign own_req    = |(req & gnt);
  assign others_any = |others;
  assign multi      = popcount(req) >= POP_W'(2);

  rr_pick4 u_pick_idle (
    .req   (req),
    .start (ptr),
    .pick  (idle_pick),
    .valid (idle_valid)
  );

  // Handover search excludes the current owner and starts just past it.
  rr_pick4 u_pick_hand (
    .req   (others),
    .start (owner_next),
    .pick  (hand_pick),
    .valid (hand_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      busy     <= (state_nxt == GRANT);
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   if (!own_req && !others_any) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt  = gnt;
    ptr_nxt  = ptr;
    hold_nxt = hold_cnt;
    case (state)
      IDLE: begin
        gnt_nxt  = idle_valid ? idle_pick : '0;
        hold_nxt = '0;
      end
      GRANT: begin
        if (own_req) begin
          if (hold_cnt < HOLD_LAST) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end else if (hand_valid) begin
            gnt_nxt  = hand_pick;
            hold_nxt = '0;
            ptr_nxt  = owner_next;
          end
        end else begin
          // Owner released: hand over with no gap, or fall back to idle.
          gnt_nxt  = hand_valid ? hand_pick : '0;
          hold_nxt = '0;
          ptr_nxt  = owner_next;
        end
      end
      default: begin
        gnt_nxt  = '0;
        hold_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention     <= 1'b0;
      contention_cnt <= '0;
    end else begin
      contention <= multi;
      if (clr) begin
        contention_cnt <= '0;
      end else if (multi && (contention_cnt != {CNT_W{1'b1}})) begin
        contention_cnt <= contention_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_double_trouble_arb.sv
// Directed bench: default arbiter plus a MAX_HOLD=1, CNT_W=2 instance on shared stimulus.
module tb_double_trouble_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [3:0] req;

  logic [3:0] gnt, gnt2;
  logic       busy, busy2;
  logic       contention, contention2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  double_trouble_arb #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .clr            (clr),
    .gnt            (gnt),
    .busy           (busy),
    .contention     (contention),
    .contention_cnt (cnt)
  );

  double_trouble_arb #(.MAX_HOLD(1), .CNT_W(2)) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .clr            (clr),
    .gnt            (gnt2),
    .busy           (busy2),
    .contention     (contention2),
    .contention_cnt (cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges, leaving inputs idle.
  task automatic do_reset();
    req   = 4'b0000;
    clr   = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int e1, e2;
    rst_n = 1'b0;
    req   = 4'b0000;
    clr   = 1'b0;
    #12;
    check("rst_gnt",  32'(gnt),        32'h0);
    check("rst_busy", 32'(busy),       32'h0);
    check("rst_cont", 32'(contention), 32'h0);
    check("rst_cnt",  32'(cnt),        32'h0);
    check("rst_gnt2", 32'(gnt2),       32'h0);
    step();
    rst_n = 1'b1;

    // Idle with no requests.
    for (int k = 1; k <= 3; k++) begin
      step();
      check("idle_gnt",  32'(gnt),  32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_cnt",  32'(cnt),  32'h0);
    end

    // Single requester held.
    req = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("solo_gnt",  32'(gnt),        32'h1);
      check("solo_busy", 32'(busy),       32'h1);
      check("solo_cont", 32'(contention), 32'h0);
      check("solo_gnt2", 32'(gnt2),       32'h1);
    end
    req = 4'b0000;
    step();
    check("release_gnt",  32'(gnt),  32'h0);
    check("release_busy", 32'(busy), 32'h0);

    // Two requesters: hold-limited alternation and counting.
    do_reset();
    req = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      step();
      e1 = (((k - 1) / 4) % 2 == 1) ? 2 : 1;
      e2 = (k % 2 == 1) ? 1 : 2;
      check("pair_gnt",  32'(gnt),        32'(e1));
      check("pair_gnt2", 32'(gnt2),       32'(e2));
      check("pair_cont", 32'(contention), 32'h1);
      check("pair_cnt",  32'(cnt),        32'(k));
      check("pair_cnt2", 32'(cnt2),       32'((k < 3) ? k : 3));
    end
    clr = 1'b1;
    step();
    check("clr_cnt",  32'(cnt),        32'h0);
    check("clr_cnt2", 32'(cnt2),       32'h0);
    check("clr_cont", 32'(contention), 32'h1);
    clr = 1'b0;
    step();
    check("post_clr_cnt", 32'(cnt), 32'h1);

    // Saturation of the narrow counter with a non-adjacent pair.
    do_reset();
    req = 4'b0110;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("sat_cnt2", 32'(cnt2), 32'((k < 3) ? k : 3));
    end

    // All four requesting: full rotation.
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      step();
      e1 = 1 << (((k - 1) / 4) % 4);
      e2 = 1 << ((k - 1) % 4);
      check("rot_gnt",  32'(gnt),  32'(e1));
      check("rot_gnt2", 32'(gnt2), 32'(e2));
    end

    // Owner drops mid-hold: immediate handover with no zero cycle.
    do_reset();
    req = 4'b1111;
    step();
    step();
    check("drop_pre_gnt",  32'(gnt),  32'h1);
    check("drop_pre_gnt2", 32'(gnt2), 32'h2);
    req = 4'b1110;
    step();
    check("drop_gnt",  32'(gnt),  32'h2);
    check("drop_busy", 32'(busy), 32'h1);
    check("drop_gnt2", 32'(gnt2), 32'h4);

    // Asynchronous reset mid-grant, then search restarts at requester 0.
    rst_n = 1'b0;
    #1;
    check("arst_gnt",  32'(gnt),        32'h0);
    check("arst_busy", 32'(busy),       32'h0);
    check("arst_cont", 32'(contention), 32'h0);
    check("arst_cnt",  32'(cnt),        32'h0);
    check("arst_gnt2", 32'(gnt2),       32'h0);
    #2;
    rst_n = 1'b1;
    req   = 4'b1100;
    step();
    check("after_rst_gnt",  32'(gnt),  32'h4);
    check("after_rst_gnt2", 32'(gnt2), 32'h4);
    req = 4'b0000;
    step();
    check("final_gnt",  32'(gnt),  32'h0);
    check("final_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/double_trouble_arb.md
DOUBLE_TROUBLE_ARB -- requirements
Module: double_trouble_arb

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles per owner while another requester is pending; legal range 1..15.
REQ-002 Parameter CNT_W, default 8: width of the contention counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  request lines; bit i belongs to requester i.
REQ-006 clr  input  1  synchronous clear of contention_cnt.
REQ-007 gnt  output  4  registered one-hot grant, or all-zero when idle.
REQ-008 busy  output  1  registered; high exactly when gnt != 0.
REQ-009 contention  output  1  registered; high when two or more req bits were set at the previous edge.
REQ-010 contention_cnt  output  CNT_W  saturating count of contention cycles.

Function
REQ-011 FSM states SHALL be IDLE and GRANT; busy SHALL equal (state == GRANT).
REQ-012 Rotation pointer ptr[1:0] SHALL select the first requester searched; search order SHALL be ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-013 IDLE with req == 0: remain IDLE; gnt = 0.
REQ-014 IDLE with req != 0: at the next edge go to GRANT, set gnt to the first set req bit in search order, and clear hold_cnt to 0; latency is one cycle.
REQ-015 GRANT, owner o with req[o] = 1 and hold_cnt < MAX_HOLD-1: keep gnt; hold_cnt increments by 1.
REQ-016 GRANT, owner o with req[o] = 1, hold_cnt == MAX_HOLD-1, and another bit set: preempt; gnt moves to the first other set bit searching from o+1; hold_cnt = 0; ptr = o+1.
REQ-017 GRANT, owner o with req[o] = 1, hold_cnt == MAX_HOLD-1, and no other bit set: keep gnt; hold_cnt saturates at MAX_HOLD-1.
REQ-018 GRANT, owner o with req[o] = 0 and other bits set: hand over at the same edge, with no idle gap, to the first set bit searching from o+1; hold_cnt = 0; ptr = o+1.
REQ-019 GRANT, owner o with req[o] = 0 and req == 0: go to IDLE; gnt = 0; ptr = o+1.
REQ-020 At most one gnt bit SHALL be high in any cycle.
REQ-021 A gnt bit SHALL never be high in a cycle after its req bit was low at the preceding edge.
REQ-022 contention SHALL register (popcount(req) >= 2) every cycle, independent of state.
REQ-023 contention_cnt SHALL increment by 1 at each edge where popcount(req) >= 2, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-024 clr = 1 SHALL load contention_cnt with 0 and SHALL take priority over a simultaneous increment.
REQ-025 With MAX_HOLD = 1, any pending other requester SHALL take over the grant after a single cycle.

Reset
REQ-026 rst_n low SHALL immediately force: state = IDLE, gnt = 0, busy = 0, contention = 0, contention_cnt = 0, ptr = 0, hold_cnt = 0.
REQ-027 Reset asserted mid-grant SHALL drop gnt without waiting for a clock edge.
REQ-028 After deassertion, the first arbitration SHALL search from requester 0.
REQ-029 Reset deassertion is synchronized externally; the block adds no synchronizer.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, GRANT), the requester count constant NREQ = 4, and the pointer width.
REQ-031 One sub-module, rr_pick4, SHALL be combinational: inputs req and start pointer; outputs a one-hot pick and a valid flag.
REQ-032 rr_pick4 SHALL be instantiated once for the IDLE search and once for the handover/preemption search.
REQ-033 All other logic SHALL live in double_trouble_arb.

Verification
REQ-034 Reset, then req = 0000 for 3 cycles -> gnt = 0000, busy = 0, contention_cnt = 0.
REQ-035 req = 0001 held 10 cycles -> gnt = 0001 from cycle 1 onward; contention stays 0.
REQ-036 req = 0011 held, MAX_HOLD = 4 -> gnt = 0001 for cycles 1-4, 0010 for cycles 5-8, 0001 again; contention = 1 from cycle 1; contention_cnt counts 1 per cycle.
REQ-037 req = 1111 held -> grants rotate 0001, 0010, 0100, 1000, 0001, each held 4 cycles; owner drops req mid-hold -> next owner granted the following cycle with no zero gap.
REQ-038 CNT_W = 2, req = 0110 for 6 cycles -> contention_cnt = 3 and holds; clr = 1 together with contention -> 0.
REQ-039 rst_n pulsed low during a grant -> gnt = 0 at once; after release with req = 1100 -> gnt = 0100, because the search starts at requester 0 and bit 2 is the first set bit.
